dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
Shares the single-port data memory (asynchronous read, synchronous write) between the pipeline MEM stage and a debug/program-loader port. The MEM stage has priority. A wait counter guarantees the debug port a grant after at most MAX_WAIT blocked cycles; on that forced grant, the arbiter stalls the pipeline for one cycle. It sits between the MEM stage and the data_memory instance.

Parameters:
MAX_WAIT, 4, debug blocked cycles before a forced grant (1..2^CNT_W-1)
CNT_W, 3, width of the wait counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
pipe_req  input  1  MEM stage needs memory this cycle (load or store)
pipe_we  input  1  MEM stage write enable
pipe_addr  input  32  MEM stage byte address
pipe_wdata  input  32  MEM stage write data (already lane-merged)
pipe_rdata  output  32  read data to MEM stage (combinational from mem_spo)
pipe_stall  output  1  hold IF/ID/EX/MEM registers this cycle
dbg_valid  input  1  debug request pending; held with fields stable until accepted
dbg_we  input  1  debug write enable
dbg_addr  input  32  debug byte address
dbg_wdata  input  32  debug write data
dbg_ready  output  1  debug request accepted this cycle (combinational)
dbg_rdata  output  32  registered debug read data
dbg_rvalid  output  1  one-cycle pulse, dbg_rdata valid
mem_a  output  32  address to data memory
mem_d  output  32  write data to data memory
mem_we  output  1  write enable to data memory
mem_spo  input  32  data memory asynchronous read data

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, on rst_n. While rst_n=0: wait_cnt=0, state=IDLE, dbg_rdata=0, dbg_rvalid=0.
- Combinational outputs during reset: pipe_stall=0, dbg_ready=0, mem_we=0.
- FSM states: IDLE (no debug request pending), WAIT (debug pending and blocked).
- Grant rule, evaluated each cycle: dbg_grant = dbg_valid && (!pipe_req || wait_cnt==MAX_WAIT).
- Debug handshake: dbg_ready = dbg_grant. Otherwise the pipeline owns the port.
- Mux when dbg_grant=1: mem_a=dbg_addr, mem_d=dbg_wdata, mem_we=dbg_we.
- Mux otherwise: mem_a=pipe_addr, mem_d=pipe_wdata, mem_we=pipe_we && pipe_req.
- Read data: pipe_rdata = mem_spo at all times. The value is only meaningful when pipe_req && !pipe_stall.
- Stall: pipe_stall = pipe_req && dbg_grant. It lasts exactly one cycle per forced grant. On the next cycle wait_cnt=0, so the pipeline wins.
- Counter: if dbg_valid && !dbg_grant, wait_cnt increments, saturating at MAX_WAIT. Otherwise wait_cnt=0.
- IDLE -> WAIT: dbg_valid && !dbg_grant.
- WAIT -> IDLE: dbg_grant, or dbg_valid falls (request withdrawn; not a legal protocol use, but wait_cnt clears).
- Debug read return: on a granted read (dbg_grant && !dbg_we), dbg_rdata <= mem_spo and dbg_rvalid <= 1 on the next edge. dbg_rvalid is 0 in every other cycle.
- Debug write return: a granted write produces no dbg_rvalid. It completes at the granting edge.
- Back-to-back debug: a new request may be presented the cycle after acceptance. It competes normally, so wait_cnt restarts at 0.
- Idle pipeline: with pipe_req=0 every cycle, each debug request is granted in its first cycle, at one access per cycle.
- Simultaneous pipe store and forced debug grant: only the debug access reaches memory. The pipeline store is replayed because the stall holds EX/MEM.
- Reset mid-operation: a pending request is dropped with no grant. The requester re-presents it after reset.
- Saturated counter: wait_cnt never exceeds MAX_WAIT and never wraps.

Test Plan:
1. Idle pipe, debug write then read: dbg write addr 0x10 data 0xDEADBEEF (dbg_ready=1 same cycle); dbg read 0x10 -> dbg_rvalid pulses next cycle with dbg_rdata=0xDEADBEEF; pipe_stall stays 0.
2. Contention with MAX_WAIT=4: pipe_req=1 every cycle, dbg_valid asserted at cycle 0 -> dbg_ready=0 for cycles 0-3; cycle 4 dbg_ready=1 and pipe_stall=1; cycle 5 pipe_stall=0 and wait_cnt=0.
3. Pipe priority: pipe store 0x20 <- 0x12345678 with dbg_valid pending (wait_cnt<4) -> mem_we, mem_a, mem_d from the pipe; a later pipe load of 0x20 -> pipe_rdata=0x12345678.
4. Forced-grant store: pipe store 0x30 <- 0xAAAA0000 collides with a forced debug write 0x30 <- 0x5555FFFF -> memory holds 0x5555FFFF after that edge; the replayed pipe store next cycle leaves 0xAAAA0000.
5. Reset mid-wait: wait_cnt=3 with dbg_valid high, pulse rst_n low -> wait_cnt=0, dbg_rvalid=0, dbg_rdata=0; after release the grant takes a full 4 blocked cycles again.
6. Pipe gap: pipe_req=1,0,1 with dbg_valid from cycle 0 -> debug granted at cycle 1 without stall; dbg_rvalid at cycle 2 for a read.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the data memory port between the MEM stage and a debug port with bounded debug wait
module dmem_port_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_req,
  input  logic        pipe_we,
  input  logic [31:0] pipe_addr,
  input  logic [31:0] pipe_wdata,
  output logic [31:0] pipe_rdata,
  output logic        pipe_stall,
  input  logic        dbg_valid,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ready,
  output logic [31:0] dbg_rdata,
  output logic        dbg_rvalid,
  output logic [31:0] mem_a,
  output logic [31:0] mem_d,
  output logic        mem_we,
  input  logic [31:0] mem_spo
);
  typedef enum logic {IDLE, WAIT} state_t;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);
  state_t           state, state_nx;
  logic [CNT_W-1:0] wait_cnt, cnt_nx;
  logic             dbg_grant, blocked, dbg_rd;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      dbg_rdata  <= '0;
      dbg_rvalid <= 1'b0;
    end else begin
      state      <= state_nx;
      wait_cnt   <= cnt_nx;
      dbg_rvalid <= dbg_rd;
      if (dbg_rd) dbg_rdata <= mem_spo;
    end
  end
  // rst_n gates the grant so no handshake, stall or write leaks out while reset is held
  always_comb begin
    dbg_grant = rst_n && dbg_valid && (!pipe_req || wait_cnt == MAX_CNT);
    blocked   = dbg_valid && !dbg_grant;
    state_nx  = blocked ? WAIT : IDLE;
    cnt_nx    = !blocked ? '0 :
                (state == IDLE) ? CNT_W'(1) :
                (wait_cnt == MAX_CNT) ? wait_cnt : wait_cnt + 1'b1;
    dbg_rd    = dbg_grant && !dbg_we;
  end
  assign dbg_ready  = dbg_grant;
  assign pipe_stall = pipe_req && dbg_grant;
  assign pipe_rdata = mem_spo;
  assign mem_a      = dbg_grant ? dbg_addr : pipe_addr;
  assign mem_d      = dbg_grant ? dbg_wdata : pipe_wdata;
  assign mem_we     = dbg_grant ? dbg_we : (rst_n && pipe_req && pipe_we);
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: scoreboard bench with a request-age reference model and a behavioural data memory
module tb_dmem_port_arbiter;
  localparam int MAX_WAIT = 4;
  logic        clk, rst_n;
  logic        pipe_req, pipe_we, pipe_stall;
  logic [31:0] pipe_addr, pipe_wdata, pipe_rdata;
  logic        dbg_valid, dbg_we, dbg_ready, dbg_rvalid;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic [31:0] mem_a, mem_d, mem_spo;
  logic        mem_we;

  dmem_port_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_req(pipe_req), .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata),
    .pipe_rdata(pipe_rdata), .pipe_stall(pipe_stall),
    .dbg_valid(dbg_valid), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ready(dbg_ready), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
    .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we), .mem_spo(mem_spo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] env_mem [64];
  assign mem_spo = env_mem[mem_a[7:2]];
  always @(posedge clk) if (mem_we) env_mem[mem_a[7:2]] <= mem_d;

  typedef struct {
    int          cyc;
    bit          rst, ready, stall, we, chk_pr;
    logic [31:0] a, d, prd;
  } rec_t;
  typedef struct {
    int          cyc;
    logic [31:0] d;
  } rd_t;
  rec_t eq[$];
  rd_t  rq[$];
  int   n_cmp = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    rec_t r;
    rd_t  x;
    bit   ev;
    if (eq.size() > 0) begin
      r = eq.pop_front();
      chk("dbg_ready", 32'(dbg_ready), 32'(r.ready));
      chk("pipe_stall", 32'(pipe_stall), 32'(r.stall));
      chk("mem_we", 32'(mem_we), 32'(r.we));
      if (!r.rst) begin
        chk("mem_a", mem_a, r.a);
        chk("mem_d", mem_d, r.d);
      end
      if (r.chk_pr) chk("pipe_rdata", pipe_rdata, r.prd);
      ev = rq.size() > 0 && rq[0].cyc == r.cyc;
      chk("dbg_rvalid", 32'(dbg_rvalid), 32'(ev));
      if (ev) begin
        x = rq.pop_front();
        chk("dbg_rdata", dbg_rdata, x.d);
      end
      if (r.rst) chk("dbg_rdata_rst", dbg_rdata, 32'h0);
    end
  end

  logic [31:0] ref_mem [64];
  int          n = 0, blocked = 0;
  bit          d_valid = 0, d_we = 0, last_stall = 0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  bit          p_req = 0, p_we = 0;
  logic [31:0] p_addr = '0, p_wdata = '0;

  task automatic dbg_req(input bit we, input logic [31:0] a, input logic [31:0] d);
    d_valid = 1; d_we = we; d_addr = a; d_wdata = d;
  endtask

  // Reference: a pending debug request wins when the pipe is idle or once it has been refused MAX_WAIT times
  task automatic step(input bit pr, input bit pwe, input logic [31:0] pa, input logic [31:0] pwd, input bit rstn);
    rec_t r;
    rd_t  x;
    bit   g;
    pipe_req = pr; pipe_we = pwe; pipe_addr = pa; pipe_wdata = pwd; rst_n = rstn;
    dbg_valid = d_valid; dbg_we = d_we; dbg_addr = d_addr; dbg_wdata = d_wdata;
    if (!rstn && rq.size() > 0 && rq[$].cyc == n) void'(rq.pop_back());
    g = rstn && d_valid && (!pr || blocked >= MAX_WAIT);
    r.cyc = n; r.rst = !rstn; r.ready = g; r.stall = pr && g;
    r.we = g ? d_we : (rstn && pr && pwe);
    r.a = g ? d_addr : pa;
    r.d = g ? d_wdata : pwd;
    r.chk_pr = rstn && pr && !g;
    r.prd = ref_mem[pa[7:2]];
    eq.push_back(r);
    if (g && !d_we) begin
      x.cyc = n + 1; x.d = ref_mem[d_addr[7:2]];
      rq.push_back(x);
    end
    if (r.we) ref_mem[r.a[7:2]] = r.d;
    blocked = (!rstn || !d_valid || g) ? 0 : (blocked < MAX_WAIT ? blocked + 1 : blocked);
    last_stall = pr && g;
    if (g) d_valid = 0;
    n++;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] raddr();
    return {24'h0, 4'($urandom_range(0, 15)), 2'b00};
  endfunction

  initial begin
    for (int i = 0; i < 64; i++) begin
      env_mem[i] <= '0;
      ref_mem[i] = '0;
    end
    rst_n = 0; pipe_req = 0; pipe_we = 0; pipe_addr = '0; pipe_wdata = '0;
    dbg_valid = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    @(posedge clk); #1;
    dbg_req(1, 32'h50, 32'h1);
    step(1, 1, 32'h4, 32'h9, 0);
    step(0, 0, 32'h0, 32'h0, 0);
    d_valid = 0;
    step(0, 0, 32'h0, 32'h0, 1);
    dbg_req(1, 32'h10, 32'hDEADBEEF);
    step(0, 0, 32'h0, 32'h0, 1);
    dbg_req(0, 32'h10, 32'h0);
    step(0, 0, 32'h0, 32'h0, 1);
    step(0, 0, 32'h0, 32'h0, 1);
    dbg_req(0, 32'h10, 32'h0);
    for (int i = 0; i < 6; i++) step(1, 0, 32'h10, 32'h0, 1);
    dbg_req(0, 32'h40, 32'h0);
    step(1, 1, 32'h20, 32'h12345678, 1);
    step(1, 0, 32'h20, 32'h0, 1);
    step(0, 0, 32'h0, 32'h0, 1);
    dbg_req(1, 32'h30, 32'h5555FFFF);
    for (int i = 0; i < 6; i++) step(1, 1, 32'h30, 32'hAAAA0000, 1);
    step(1, 0, 32'h30, 32'h0, 1);
    dbg_req(0, 32'h30, 32'h0);
    for (int i = 0; i < 3; i++) step(1, 0, 32'h8, 32'h0, 1);
    step(1, 0, 32'h8, 32'h0, 0);
    step(1, 0, 32'h8, 32'h0, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 32'h8, 32'h0, 1);
    dbg_req(0, 32'h20, 32'h0);
    step(1, 0, 32'h30, 32'h0, 1);
    step(0, 0, 32'h0, 32'h0, 1);
    step(1, 0, 32'h30, 32'h0, 1);
    step(0, 0, 32'h0, 32'h0, 1);
    for (int i = 0; i < 3000; i++) begin
      if (!d_valid && $urandom_range(0, 2) == 0) dbg_req(1'($urandom), raddr(), $urandom);
      if (!last_stall) begin
        p_req = $urandom_range(0, 3) != 0; p_we = 1'($urandom);
        p_addr = raddr(); p_wdata = $urandom;
      end
      step(p_req, p_we, p_addr, p_wdata, $urandom_range(0, 299) != 0);
    end
    for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 32'h0, 1);
    @(negedge clk); #1;
    chk("scoreboard_drain", 32'(eq.size() + rq.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
